// File: rtl/systolic_feeder_if.sv
// Source-side handshake and skewed PE-network streams of the systolic feeder.
interface systolic_feeder_if #(
  parameter int N = 8,
  parameter int X = 6,
  parameter int Y = 24
);
  logic           start;
  logic [X*N-1:0] a_in;
  logic [Y*N-1:0] b_in;
  logic           in_valid;
  logic           in_ready;
  logic [X*N-1:0] A0;
  logic [Y*N-1:0] B0;
  logic           sn;
  logic           busy;
  logic           done;

  modport master (
    output start, a_in, b_in, in_valid,
    input  in_ready, A0, B0, sn, busy, done
  );

  modport slave (
    input  start, a_in, b_in, in_valid,
    output in_ready, A0, B0, sn, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Feeds A columns / B rows into a systolic PE array with per-lane skew,
// clearing accumulators first and flushing the skew chains afterwards.
module systolic_feeder #(
  parameter int N = 8,
  parameter int X = 6,
  parameter int Y = 24,
  parameter int K = 8
) (
  input logic         clk,
  input logic         rst,
  systolic_feeder_if.slave bus
);

  localparam int M  = (X > Y) ? X : Y;
  localparam int BW = $clog2(K + 1);
  localparam int FW = $clog2(M + 1);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    FEED,
    FLUSH
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic          acc;
  logic          last_beat;
  logic          last_flush;

  assign acc        = bus.in_valid && (state_q == FEED);
  assign last_beat  = beat_q == BW'(K - 1);
  assign last_flush = flush_q == FW'(M - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    flush_d      = flush_q;
    bus.sn       = 1'b0;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_d = CLR;
      end
      CLR: begin
        bus.sn  = 1'b1;
        state_d = FEED;
      end
      FEED: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = FLUSH;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (last_flush) begin
          bus.done = 1'b1;
          flush_d  = '0;
          state_d  = IDLE;
        end else begin
          flush_d = flush_q + 1'b1;
        end
      end
    endcase
  end

  // Lane i gets a chain of depth i+1; idle cycles push zero bubbles.
  for (genvar i = 0; i < X; i++) begin : g_a
    logic [N-1:0] ch_q [i+1];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s <= i; s++) ch_q[s] <= '0;
      end else begin
        ch_q[0] <= acc ? bus.a_in[(X-i)*N-1 -: N] : '0;
        for (int s = 1; s <= i; s++) ch_q[s] <= ch_q[s-1];
      end
    end
    assign bus.A0[(X-i)*N-1 -: N] = ch_q[i];
  end

  for (genvar j = 0; j < Y; j++) begin : g_b
    logic [N-1:0] ch_q [j+1];
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s <= j; s++) ch_q[s] <= '0;
      end else begin
        ch_q[0] <= acc ? bus.b_in[(Y-j)*N-1 -: N] : '0;
        for (int s = 1; s <= j; s++) ch_q[s] <= ch_q[s-1];
      end
    end
    assign bus.B0[(Y-j)*N-1 -: N] = ch_q[j];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a small 2x2 K=2 instance and a default 6x24 K=8
// instance, checked cycle by cycle against a timeline/history model.
module tb_systolic_feeder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_feeder_if #(.N(8), .X(2), .Y(2))  sif ();
  systolic_feeder_if #(.N(8), .X(6), .Y(24)) dif ();

  systolic_feeder #(.N(8), .X(2), .Y(2), .K(2)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  systolic_feeder #(.N(8), .X(6), .Y(24), .K(8)) u_dflt (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int n_chk;
  int n_fail;
  int sel, cx, cy, ck, cm;
  int cyc, start_cyc, acc, done_cyc;
  int sn_seen, done_seen;
  logic [7:0] ha [0:2047][0:5];
  logic [7:0] hb [0:2047][0:23];
  logic [7:0] da [0:5];
  logic [7:0] db [0:23];

  function automatic bit finished();
    return (done_cyc >= 0) && (cyc > done_cyc);
  endfunction

  task automatic zero_inputs();
    sif.start = 1'b0; sif.in_valid = 1'b0;
    sif.a_in = '0; sif.b_in = '0;
    dif.start = 1'b0; dif.in_valid = 1'b0;
    dif.a_in = '0; dif.b_in = '0;
  endtask

  task automatic rand_inputs();
    sif.start = 1'($urandom); sif.in_valid = 1'($urandom);
    sif.a_in = 16'($urandom); sif.b_in = 16'($urandom);
    dif.start = 1'($urandom); dif.in_valid = 1'($urandom);
    dif.a_in = 48'({$urandom, $urandom});
    dif.b_in = {$urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom};
  endtask

  task automatic do_reset(input int s);
    @(negedge clk);
    rst = 1'b0;
    rand_inputs();
    repeat (2) @(negedge clk);
    zero_inputs();
    rst = 1'b1;
    sel = s;
    cx = (s == 0) ? 2 : 6;
    cy = (s == 0) ? 2 : 24;
    ck = (s == 0) ? 2 : 8;
    cm = (cx > cy) ? cx : cy;
    cyc = 0; start_cyc = -1; acc = 0; done_cyc = -1;
    sn_seen = 0; done_seen = 0;
  endtask

  // One clock: check DUT against the model, then drive this cycle's inputs.
  task automatic cycle(input bit st, input bit v, input bit rnd);
    logic [191:0] ea, eb, aa, ab, pa, pb;
    logic e_sn, e_rdy, e_busy, e_done, idle, acpt;
    logic a_sn, a_rdy, a_busy, a_done;
    int s;
    @(negedge clk);
    idle   = (start_cyc < 0) || finished();
    e_sn   = !idle && (cyc == start_cyc + 1);
    e_rdy  = !idle && (cyc >= start_cyc + 2) && (acc < ck);
    e_busy = !idle;
    e_done = !idle && (cyc == done_cyc);
    ea = '0; eb = '0;
    for (int i = 0; i < cx; i++) begin
      s = cyc - i - 1;
      if (s >= 0) ea[(cx-i)*8-1 -: 8] = ha[s % 2048][i];
    end
    for (int j = 0; j < cy; j++) begin
      s = cyc - j - 1;
      if (s >= 0) eb[(cy-j)*8-1 -: 8] = hb[s % 2048][j];
    end
    if (sel == 0) begin
      aa = 192'(sif.A0); ab = 192'(sif.B0);
      a_sn = sif.sn; a_rdy = sif.in_ready;
      a_busy = sif.busy; a_done = sif.done;
    end else begin
      aa = 192'(dif.A0); ab = 192'(dif.B0);
      a_sn = dif.sn; a_rdy = dif.in_ready;
      a_busy = dif.busy; a_done = dif.done;
    end
    n_chk++;
    if (a_sn !== e_sn) begin
      n_fail++;
      $display("FAIL sn inst=%0d cyc=%0d got=%b exp=%b", sel, cyc, a_sn, e_sn);
    end
    n_chk++;
    if (a_rdy !== e_rdy) begin
      n_fail++;
      $display("FAIL in_ready inst=%0d cyc=%0d got=%b exp=%b", sel, cyc, a_rdy, e_rdy);
    end
    n_chk++;
    if (a_busy !== e_busy) begin
      n_fail++;
      $display("FAIL busy inst=%0d cyc=%0d got=%b exp=%b", sel, cyc, a_busy, e_busy);
    end
    n_chk++;
    if (a_done !== e_done) begin
      n_fail++;
      $display("FAIL done inst=%0d cyc=%0d got=%b exp=%b", sel, cyc, a_done, e_done);
    end
    n_chk++;
    if (aa !== ea) begin
      n_fail++;
      $display("FAIL A0 inst=%0d cyc=%0d got=%h exp=%h", sel, cyc, aa, ea);
    end
    n_chk++;
    if (ab !== eb) begin
      n_fail++;
      $display("FAIL B0 inst=%0d cyc=%0d got=%h exp=%h", sel, cyc, ab, eb);
    end
    sn_seen += int'(a_sn);
    done_seen += int'(a_done);
    if (rnd) begin
      for (int i = 0; i < cx; i++) da[i] = 8'($urandom);
      for (int j = 0; j < cy; j++) db[j] = 8'($urandom);
    end
    acpt = e_rdy && v;
    for (int i = 0; i < 6; i++) ha[cyc % 2048][i] = (acpt && i < cx) ? da[i] : 8'h00;
    for (int j = 0; j < 24; j++) hb[cyc % 2048][j] = (acpt && j < cy) ? db[j] : 8'h00;
    pa = '0; pb = '0;
    for (int i = 0; i < cx; i++) pa[(cx-i)*8-1 -: 8] = da[i];
    for (int j = 0; j < cy; j++) pb[(cy-j)*8-1 -: 8] = db[j];
    zero_inputs();
    if (sel == 0) begin
      sif.start = st; sif.in_valid = v;
      sif.a_in = pa[15:0]; sif.b_in = pb[15:0];
    end else begin
      dif.start = st; dif.in_valid = v;
      dif.a_in = pa[47:0]; dif.b_in = pb;
    end
    if (acpt) begin
      acc++;
      if (acc == ck) done_cyc = cyc + cm;
    end
    if (idle && st) begin
      start_cyc = cyc; acc = 0; done_cyc = -1;
    end
    cyc++;
  endtask

  task automatic run_to_idle(input bit st, input int vpct, input bit rnd);
    int n;
    n = 0;
    while (!finished() && n < 400) begin
      cycle(st, ($urandom % 100) < vpct, rnd);
      n++;
    end
    n_chk++;
    if (n >= 400) begin
      n_fail++;
      $display("FAIL timeout inst=%0d got=%0d cycles exp<400", sel, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int it = 0; it < 4; it++) begin
      rand_inputs();
      #3;
      n_chk++;
      if ({sif.A0, sif.B0, sif.sn, sif.in_ready, sif.busy, sif.done} !== '0) begin
        n_fail++;
        $display("FAIL reset_small got=%h exp=0",
                 {sif.A0, sif.B0, sif.sn, sif.in_ready, sif.busy, sif.done});
      end
      n_chk++;
      if ({dif.A0, dif.B0, dif.sn, dif.in_ready, dif.busy, dif.done} !== '0) begin
        n_fail++;
        $display("FAIL reset_dflt got=%h exp=0",
                 {dif.A0, dif.B0, dif.sn, dif.in_ready, dif.busy, dif.done});
      end
    end
    do_reset(1);
    repeat (10) cycle(1'b0, 1'($urandom), 1'b1);
  endtask

  task automatic test_basic_skew();
    do_reset(0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    n_chk++;
    if (sif.sn !== 1'b1) begin
      n_fail++; $display("FAIL skew_sn got=%b exp=1", sif.sn);
    end
    da[0] = 8'h11; da[1] = 8'h12; db[0] = 8'h21; db[1] = 8'h22;
    cycle(1'b0, 1'b1, 1'b0);
    n_chk++;
    if (sif.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL skew_ready got=%b exp=1", sif.in_ready);
    end
    da[0] = 8'h33; da[1] = 8'h34; db[0] = 8'h43; db[1] = 8'h44;
    cycle(1'b0, 1'b1, 1'b0);
    n_chk++;
    if ({sif.A0[15:8], sif.B0[15:8]} !== 16'h1121) begin
      n_fail++;
      $display("FAIL skew_lane0 got=%h exp=1121", {sif.A0[15:8], sif.B0[15:8]});
    end
    cycle(1'b0, 1'b0, 1'b1);
    n_chk++;
    if ({sif.A0, sif.B0[7:0]} !== 24'h331222) begin
      n_fail++;
      $display("FAIL skew_lane1 got=%h exp=331222", {sif.A0, sif.B0[7:0]});
    end
    cycle(1'b0, 1'b0, 1'b1);
    n_chk++;
    if ({sif.done, sif.A0[7:0], sif.B0[7:0]} !== 17'h13444) begin
      n_fail++;
      $display("FAIL skew_done got=%h exp=13444", {sif.done, sif.A0[7:0], sif.B0[7:0]});
    end
    cycle(1'b0, 1'b0, 1'b1);
    n_chk++;
    if ({sif.A0, sif.B0, sif.busy} !== '0) begin
      n_fail++;
      $display("FAIL skew_after got=%h exp=0", {sif.A0, sif.B0, sif.busy});
    end
  endtask

  task automatic test_bubble();
    do_reset(0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b1);
    n_chk++;
    if ({sif.A0, sif.B0} !== 32'h0) begin
      n_fail++; $display("FAIL bubble_zero got=%h exp=0", {sif.A0, sif.B0});
    end
    cycle(1'b0, 1'b1, 1'b1);
    run_to_idle(1'b0, 50, 1'b1);
    n_chk++;
    if (done_seen != 1) begin
      n_fail++; $display("FAIL bubble_done_count got=%0d exp=1", done_seen);
    end
  endtask

  task automatic test_ignored_start();
    int n;
    do_reset(1);
    cycle(1'b1, 1'b0, 1'b1);
    n = 0;
    while (!finished() && n < 300) begin
      cycle(1'b1, 1'($urandom), 1'b1);
      n++;
    end
    n_chk++;
    if (sn_seen != 1 || n >= 300) begin
      n_fail++; $display("FAIL ign_start_sn got=%0d exp=1 (n=%0d)", sn_seen, n);
    end
    cycle(1'b1, 1'b0, 1'b1);
    run_to_idle(1'b0, 60, 1'b1);
    n_chk++;
    if (sn_seen != 2 || done_seen != 2) begin
      n_fail++;
      $display("FAIL ign_start_second got=sn%0d/done%0d exp=sn2/done2", sn_seen, done_seen);
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({dif.A0, dif.B0, dif.sn, dif.in_ready, dif.busy, dif.done} !== '0
        || done_seen != 0) begin
      n_fail++;
      $display("FAIL mid_reset got=%h done_seen=%0d exp=0",
               {dif.A0, dif.B0, dif.busy, dif.done}, done_seen);
    end
    do_reset(1);
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) da[i] = 8'hAA;
    for (int j = 0; j < 24; j++) db[j] = 8'hAA;
    run_to_idle(1'b0, 100, 1'b0);
    n_chk++;
    if (done_seen != 1) begin
      n_fail++; $display("FAIL mid_reset_rerun got=%0d exp=1", done_seen);
    end
  endtask

  task automatic test_default_stream();
    int acc_at [8];
    int rec, pk, n, bc;
    do_reset(1);
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) da[i] = 8'(i + 1);
    for (int j = 0; j < 24; j++) db[j] = 8'(j + 1);
    cycle(1'b1, 1'b0, 1'b0);
    rec = 0; n = 0; bc = 0;
    while (!finished() && n < 300) begin
      pk = acc;
      cycle(1'b0, ($urandom % 4) != 0, 1'b0);
      n++;
      bc += int'(dif.busy);
      if (acc != pk) begin
        acc_at[rec] = cyc - 1;
        rec++;
        for (int i = 0; i < 6; i++) da[i] = 8'(rec * 16 + i + 1);
        for (int j = 0; j < 24; j++) db[j] = 8'(rec * 16 + j + 1);
      end
      for (int q = 0; q < rec; q++) begin
        if (acc_at[q] + cx == cyc - 1) begin
          n_chk++;
          if (dif.A0[7:0] !== 8'(q * 16 + cx)) begin
            n_fail++;
            $display("FAIL stream_lastlane beat=%0d got=%h exp=%h",
                     q, dif.A0[7:0], 8'(q * 16 + cx));
          end
        end
      end
    end
    n_chk++;
    if (done_seen != 1 || bc != done_cyc - start_cyc || n >= 300) begin
      n_fail++;
      $display("FAIL stream_busy_done got=busy%0d/done%0d exp=busy%0d/done1",
               bc, done_seen, done_cyc - start_cyc);
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      do_reset(s);
      repeat (300) cycle(($urandom % 4) == 0, ($urandom % 3) != 0, 1'b1);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    sel = 0; cx = 2; cy = 2; ck = 2; cm = 2;
    cyc = 0; start_cyc = -1; acc = 0; done_cyc = -1;
    sn_seen = 0; done_seen = 0;
    rst = 1'b0;
    zero_inputs();
    test_reset();
    test_basic_skew();
    test_bubble();
    test_ignored_start();
    test_mid_reset();
    test_default_stream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
